// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//   Control FSM for a multicycle RV32I core. It sequences fetch, decode,
//   execute, an optional multicycle mul/div wait, memory access, write-back,
//   trap entry and WFI sleep. It produces register write enables, memory
//   command strobes and the trap cause / trap value selection. Datapath
//   select decode lives elsewhere; this block only sequences.
//
//   Build option: define MULDIV_EN to route OP/funct7=0000001 through the
//   MULDIV wait state. Without it those encodings are illegal instructions.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   instruction             latched instruction register
//   next_pc                 computed next PC (only [1:0] used, alignment)
//   mem_ready/valid/error   memory handshake; error qualified by valid
//   misaligned              load/store address misaligned
//   irq_pending, irq_enable level interrupt requests, global enable
//   muldiv_done             multicycle unit result ready
//   *_we                    register write enables
//   mem_enable/command      issue a memory command, 0 = read, 1 = write
//   mem_addr_from_exec      memory address from execute result
//   muldiv_start            start pulse to the multicycle unit
//   handle_trap, exit_trap  trap entry / MRET strobes
//   exception, exception_cause, trap_value_type  trap status registers
//   retired                 one pulse per retired instruction
//   debug_state             current FSM state
// -----------------------------------------------------------------------------
module multicycle_sequencer #(
  parameter int NUM_IRQ        = 4,
  parameter int IRQ_CAUSE_BASE = 16,
  parameter int MEM_TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        instruction,
  input  logic [31:0]        next_pc,
  input  logic               mem_ready,
  input  logic               mem_valid,
  input  logic               mem_error,
  input  logic               misaligned,
  input  logic [NUM_IRQ-1:0] irq_pending,
  input  logic               irq_enable,
  input  logic               muldiv_done,
  output logic               instruction_we,
  output logic               execute_we,
  output logic               load_we,
  output logic               pc_we,
  output logic               rf_we,
  output logic               mem_enable,
  output logic               mem_command,
  output logic               mem_addr_from_exec,
  output logic               muldiv_start,
  output logic               handle_trap,
  output logic               exit_trap,
  output logic               exception,
  output logic [30:0]        exception_cause,
  output logic               trap_value_type,
  output logic               retired,
  output logic [2:0]         debug_state
);

  typedef enum logic [2:0] {
    S_FETCH      = 3'd0,
    S_DECODE     = 3'd1,
    S_EXECUTE    = 3'd2,
    S_MULDIV     = 3'd3,
    S_MEMORY     = 3'd4,
    S_WRITE_BACK = 3'd5,
    S_TRAP       = 3'd6,
    S_WFI        = 3'd7
  } state_t;

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int IDX_W = (NUM_IRQ < 2) ? 1 : $clog2(NUM_IRQ);
  localparam bit TIMEOUT_ON = (MEM_TIMEOUT != 0);
  // The counter holds the number of completed wait cycles, so the last
  // allowed wait cycle is the one that sees MEM_TIMEOUT-1.
  localparam int TO_LAST = TIMEOUT_ON ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TO_LAST);

  localparam logic [30:0] CAUSE_INSN_MISALIGN = 31'd0;
  localparam logic [30:0] CAUSE_FETCH_FAULT   = 31'd1;
  localparam logic [30:0] CAUSE_ILLEGAL       = 31'd2;
  localparam logic [30:0] CAUSE_BREAKPOINT    = 31'd3;
  localparam logic [30:0] CAUSE_LOAD_MISALIGN = 31'd4;
  localparam logic [30:0] CAUSE_LOAD_FAULT    = 31'd5;
  localparam logic [30:0] CAUSE_STORE_MISALIGN= 31'd6;
  localparam logic [30:0] CAUSE_STORE_FAULT   = 31'd7;
  localparam logic [30:0] CAUSE_ECALL_M       = 31'd11;

  state_t            state_q, state_d;
  logic              exc_q, exc_d;
  logic [30:0]       cause_q, cause_d;
  logic              tval_q, tval_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;   // memory command outstanding

  // ---------------------------------------------------------------------------
  // Instruction classification
  // ---------------------------------------------------------------------------
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
  logic is_op_imm, is_op, is_fence, is_system;
  logic is_ecall, is_ebreak, is_mret, is_wfi, is_csr, is_mop;
  logic shift_bad, op_bad, system_bad, illegal, writes_rd;

  assign is_lui    = (opcode == 7'b0110111);
  assign is_auipc  = (opcode == 7'b0010111);
  assign is_jal    = (opcode == 7'b1101111);
  assign is_jalr   = (opcode == 7'b1100111);
  assign is_branch = (opcode == 7'b1100011);
  assign is_load   = (opcode == 7'b0000011);
  assign is_store  = (opcode == 7'b0100011);
  assign is_op_imm = (opcode == 7'b0010011);
  assign is_op     = (opcode == 7'b0110011);
  assign is_fence  = (opcode == 7'b0001111);
  assign is_system = (opcode == 7'b1110011);

  assign is_ecall  = (instruction == 32'h0000_0073);
  assign is_ebreak = (instruction == 32'h0010_0073);
  assign is_mret   = (instruction == 32'h3020_0073);
  assign is_wfi    = (instruction == 32'h1050_0073);
  assign is_csr    = is_system && (funct3 != 3'b000) && (funct3 != 3'b100);
  assign is_mop    = is_op && (funct7 == 7'b0000001);

  // Immediate shifts carry funct7 in the upper immediate bits; only the
  // logical (0000000) and arithmetic right (0100000) forms exist.
  assign shift_bad = is_op_imm &&
                     (((funct3 == 3'b001) && (funct7 != 7'b0000000)) ||
                      ((funct3 == 3'b101) && (funct7 != 7'b0000000) &&
                       (funct7 != 7'b0100000)));
  assign op_bad    = is_op && !((funct7 == 7'b0000000) || is_mop ||
                      ((funct7 == 7'b0100000) &&
                       ((funct3 == 3'b000) || (funct3 == 3'b101))));
  assign system_bad = is_system &&
                      !(is_ecall || is_ebreak || is_mret || is_wfi || is_csr);

`ifdef MULDIV_EN
  assign illegal = !(is_lui || is_auipc || is_jal || is_jalr || is_branch ||
                     is_load || is_store || is_op_imm || is_op || is_fence ||
                     is_system) || shift_bad || op_bad || system_bad;
`else
  assign illegal = !(is_lui || is_auipc || is_jal || is_jalr || is_branch ||
                     is_load || is_store || is_op_imm || is_op || is_fence ||
                     is_system) || shift_bad || op_bad || system_bad || is_mop;
`endif

  assign writes_rd = is_lui || is_auipc || is_jal || is_jalr || is_load ||
                     is_op || is_op_imm || is_csr;

  // ---------------------------------------------------------------------------
  // Interrupt priority: lowest set index wins
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] irq_idx;
  always_comb begin
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_pending[i]) irq_idx = IDX_W'(i);
    end
  end

  logic [30:0] irq_cause;
  assign irq_cause = 31'(IRQ_CAUSE_BASE) + 31'(irq_idx);

  // ---------------------------------------------------------------------------
  // Memory handshake helpers shared by FETCH and MEMORY
  // ---------------------------------------------------------------------------
  logic mem_issue, mem_resp, mem_wait, mem_expire;
  assign mem_issue  = mem_ready && !pend_q;
  assign mem_resp   = pend_q && mem_valid;
  assign mem_wait   = pend_q && !mem_valid;
  assign mem_expire = TIMEOUT_ON && mem_wait && (cnt_q == TO_LAST_C);

  // ---------------------------------------------------------------------------
  // State and status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      exc_q   <= 1'b0;
      cause_q <= '0;
      tval_q  <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
      cause_q <= cause_d;
      tval_q  <= tval_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and strobes
  // ---------------------------------------------------------------------------
  logic        take_trap;
  logic [30:0] trap_cause;
  logic        trap_tval;

  always_comb begin
    state_d            = state_q;
    exc_d              = exc_q;
    cause_d            = cause_q;
    tval_d             = tval_q;
    cnt_d              = cnt_q;
    pend_d             = pend_q;
    take_trap          = 1'b0;
    trap_cause         = '0;
    trap_tval          = 1'b0;
    instruction_we     = 1'b0;
    execute_we         = 1'b0;
    load_we            = 1'b0;
    pc_we              = 1'b0;
    rf_we              = 1'b0;
    mem_enable         = 1'b0;
    mem_command        = 1'b0;
    mem_addr_from_exec = 1'b0;
    handle_trap        = 1'b0;
    exit_trap          = 1'b0;
    retired            = 1'b0;
`ifdef MULDIV_EN
    muldiv_start       = 1'b0;
`endif

    // Strobes are combinational, so they are forced quiet while in reset.
    if (reset_n) begin
      case (state_q)
        S_FETCH: begin
          exc_d   = 1'b0;
          cause_d = '0;
          tval_d  = 1'b0;
          if (mem_issue) begin
            mem_enable = 1'b1;
            pend_d     = 1'b1;
            cnt_d      = '0;
          end else if (mem_resp) begin
            if (mem_error) begin
              take_trap  = 1'b1;
              trap_cause = CAUSE_FETCH_FAULT;
            end else begin
              instruction_we = 1'b1;
              state_d        = S_DECODE;
            end
          end else if (mem_expire) begin
            take_trap  = 1'b1;
            trap_cause = CAUSE_FETCH_FAULT;
          end else if (mem_wait && TIMEOUT_ON) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_DECODE: begin
          if (irq_enable && (|irq_pending)) begin
            take_trap  = 1'b1;
            trap_cause = irq_cause;
          end else begin
            state_d = S_EXECUTE;
          end
        end

        S_EXECUTE: begin
          execute_we = 1'b1;
          if (illegal) begin
            take_trap  = 1'b1;
            trap_cause = CAUSE_ILLEGAL;
          end else if (is_ecall) begin
            take_trap  = 1'b1;
            trap_cause = CAUSE_ECALL_M;
          end else if (is_ebreak) begin
            take_trap  = 1'b1;
            trap_cause = CAUSE_BREAKPOINT;
          end else if (is_load || is_store) begin
            state_d = S_MEMORY;
          end else if (is_wfi) begin
            state_d = S_WFI;
`ifdef MULDIV_EN
          end else if (is_mop) begin
            muldiv_start = 1'b1;
            state_d      = S_MULDIV;
`endif
          end else begin
            state_d = S_WRITE_BACK;
          end
        end

        S_MULDIV: begin
`ifdef MULDIV_EN
          if (muldiv_done) begin
            execute_we = 1'b1;
            state_d    = S_WRITE_BACK;
          end
`else
          state_d = S_FETCH;
`endif
        end

        S_MEMORY: begin
          mem_addr_from_exec = 1'b1;
          if (misaligned) begin
            // Checked before any issue so a misaligned access never
            // reaches the bus.
            take_trap  = 1'b1;
            trap_cause = is_store ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
            trap_tval  = 1'b1;
          end else if (mem_issue) begin
            mem_enable  = 1'b1;
            mem_command = is_store;
            pend_d      = 1'b1;
            cnt_d       = '0;
          end else if (mem_resp) begin
            if (mem_error) begin
              take_trap  = 1'b1;
              trap_cause = is_store ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
            end else begin
              load_we = is_load;
              state_d = S_WRITE_BACK;
            end
          end else if (mem_expire) begin
            take_trap  = 1'b1;
            trap_cause = is_store ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
          end else if (mem_wait && TIMEOUT_ON) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_WRITE_BACK: begin
          // An untaken branch has next_pc = pc + 4, which is always aligned,
          // so checking every branch is equivalent to checking taken ones.
          if ((is_jal || is_jalr || is_branch) && (next_pc[1:0] != 2'b00)) begin
            take_trap  = 1'b1;
            trap_cause = CAUSE_INSN_MISALIGN;
          end else begin
            pc_we     = 1'b1;
            retired   = 1'b1;
            rf_we     = writes_rd;
            exit_trap = is_mret;
            state_d   = S_FETCH;
          end
        end

        S_TRAP: begin
          pc_we       = 1'b1;
          handle_trap = 1'b1;
          state_d     = S_FETCH;
        end

        S_WFI: begin
          if (|irq_pending) state_d = S_WRITE_BACK;
        end

        default: state_d = S_FETCH;
      endcase
    end

    if (take_trap) begin
      state_d = S_TRAP;
      exc_d   = 1'b1;
      cause_d = trap_cause;
      tval_d  = trap_tval;
    end

    // Leaving a state abandons any access bookkeeping.
    if (state_d != state_q) begin
      cnt_d  = '0;
      pend_d = 1'b0;
    end
  end

`ifndef MULDIV_EN
  assign muldiv_start = 1'b0;
  logic unused_muldiv;
  assign unused_muldiv = muldiv_done;
`endif

  logic unused_pc;
  assign unused_pc = ^next_pc[31:2];

  assign exception       = exc_q;
  assign exception_cause = cause_q;
  assign trap_value_type = tval_q;
  assign debug_state     = state_q;

endmodule
